// File: rtl/cur_mb_ctrl.sv
// Current-macroblock controller: sequences the loader and pipeline through a frame in raster
// order. It keeps at most one macroblock buffered ahead of the pipeline.
module cur_mb_ctrl #(
    parameter int MB_W = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            sys_start,
    input  logic [MB_W-1:0] sys_x_total,
    input  logic [MB_W-1:0] sys_y_total,
    output logic            load_start,
    input  logic            load_done,
    output logic            mb_switch,
    input  logic            pipe_done,
    output logic [MB_W-1:0] mb_x_load,
    output logic [MB_W-1:0] mb_y_load,
    output logic [MB_W-1:0] mb_x_cur,
    output logic [MB_W-1:0] mb_y_cur,
    output logic            busy,
    output logic            frame_done
);

    typedef enum logic [1:0] {IDLE, WAIT_LOAD, WAIT_PIPE, DRAIN} state_t;

    localparam logic [MB_W-1:0] ONE = {{(MB_W-1){1'b0}}, 1'b1};

    state_t          state_reg, state_next;
    logic [MB_W-1:0] x_total_reg, y_total_reg, x_total_next, y_total_next;
    logic [MB_W-1:0] x_load_next, y_load_next, x_cur_next, y_cur_next;
    logic            pipe_busy_reg, pipe_busy_next;
    logic            load_start_next, mb_switch_next, busy_next, frame_done_next;
    logic            pipe_free, last_mb, do_switch;

    assign pipe_free = ~pipe_busy_reg | pipe_done;
    assign last_mb   = (mb_x_load == x_total_reg) && (mb_y_load == y_total_reg);

    always_comb begin
        state_next      = state_reg;
        x_total_next    = x_total_reg;
        y_total_next    = y_total_reg;
        x_load_next     = mb_x_load;
        y_load_next     = mb_y_load;
        x_cur_next      = mb_x_cur;
        y_cur_next      = mb_y_cur;
        load_start_next = 1'b0;
        mb_switch_next  = 1'b0;
        frame_done_next = 1'b0;
        busy_next       = busy;
        do_switch       = 1'b0;

        case (state_reg)
            IDLE: begin
                if (sys_start) begin
                    x_total_next    = sys_x_total;
                    y_total_next    = sys_y_total;
                    x_load_next     = '0;
                    y_load_next     = '0;
                    load_start_next = 1'b1;
                    busy_next       = 1'b1;
                    state_next      = WAIT_LOAD;
                end
            end
            WAIT_LOAD: begin
                if (load_done) begin
                    if (pipe_free) do_switch = 1'b1;
                    else           state_next = WAIT_PIPE;
                end
            end
            WAIT_PIPE: begin
                if (pipe_free) do_switch = 1'b1;
            end
            DRAIN: begin
                if (pipe_done && pipe_busy_reg) begin
                    frame_done_next = 1'b1;
                    busy_next       = 1'b0;
                    state_next      = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        // Hand the buffered MB to the pipeline and, unless it was the last, refill the buffer.
        if (do_switch) begin
            mb_switch_next = 1'b1;
            x_cur_next     = mb_x_load;
            y_cur_next     = mb_y_load;
            if (last_mb) begin
                state_next = DRAIN;
            end else begin
                load_start_next = 1'b1;
                state_next      = WAIT_LOAD;
                if (mb_x_load == x_total_reg) begin
                    x_load_next = '0;
                    y_load_next = mb_y_load + ONE;
                end else begin
                    x_load_next = mb_x_load + ONE;
                end
            end
        end

        // A new MB entering wins over the old one leaving in the same cycle.
        if (do_switch)      pipe_busy_next = 1'b1;
        else if (pipe_done) pipe_busy_next = 1'b0;
        else                pipe_busy_next = pipe_busy_reg;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            x_total_reg   <= '0;
            y_total_reg   <= '0;
            mb_x_load     <= '0;
            mb_y_load     <= '0;
            mb_x_cur      <= '0;
            mb_y_cur      <= '0;
            pipe_busy_reg <= 1'b0;
            load_start    <= 1'b0;
            mb_switch     <= 1'b0;
            frame_done    <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state_reg     <= state_next;
            x_total_reg   <= x_total_next;
            y_total_reg   <= y_total_next;
            mb_x_load     <= x_load_next;
            mb_y_load     <= y_load_next;
            mb_x_cur      <= x_cur_next;
            mb_y_cur      <= y_cur_next;
            pipe_busy_reg <= pipe_busy_next;
            load_start    <= load_start_next;
            mb_switch     <= mb_switch_next;
            frame_done    <= frame_done_next;
            busy          <= busy_next;
        end
    end

endmodule

// File: doc/cur_mb_ctrl.md
CUR_MB_CTRL -- requirements
Module: cur_mb_ctrl

Interface
REQ-001 Parameter: MB_W, default 8, width of every macroblock coordinate and frame-size field.
REQ-002 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: sys_start  input  1  one-cycle pulse that starts encoding of one frame.
REQ-005 Port: sys_x_total  input  MB_W  frame width in macroblocks minus 1; sampled only when a start is accepted.
REQ-006 Port: sys_y_total  input  MB_W  frame height in macroblocks minus 1; sampled only when a start is accepted.
REQ-007 Port: load_start  output  1  one-cycle pulse that tells the current-MB loader to fetch the next macroblock.
REQ-008 Port: load_done  input  1  one-cycle pulse; the loader buffer holds a complete macroblock.
REQ-009 Port: mb_switch  output  1  one-cycle pulse that moves the loaded macroblock into the pipeline stage registers.
REQ-010 Port: pipe_done  input  1  one-cycle pulse; the pipeline has finished the macroblock in its stage registers.
REQ-011 Port: mb_x_load, mb_y_load  output  MB_W each  coordinates of the macroblock being loaded or held in the buffer.
REQ-012 Port: mb_x_cur, mb_y_cur  output  MB_W each  coordinates of the macroblock in the pipeline.
REQ-013 Port: busy  output  1  high from start acceptance until frame_done.
REQ-014 Port: frame_done  output  1  one-cycle pulse; the last macroblock of the frame has completed.

Function
REQ-015 States: IDLE, WAIT_LOAD, WAIT_PIPE, DRAIN.
REQ-016 Outputs: all outputs are registered; load_start, mb_switch and frame_done are single-cycle pulses.
REQ-017 Pipeline occupancy: an internal flag pipe_busy is set on each mb_switch and cleared on pipe_done.
REQ-018 Pipeline free: the pipeline counts as free in a cycle where pipe_busy=0, or where pipe_done=1.
REQ-019 IDLE start: on sys_start the block latches both totals, sets load coordinates to (0,0), pulses load_start in the next cycle, sets busy=1 and moves to WAIT_LOAD.
REQ-020 WAIT_LOAD, load_done with pipeline free: mb_switch pulses in the cycle after load_done, and the cur coordinates take the load coordinates.
REQ-021 WAIT_LOAD, load_done with pipeline not free: the block moves to WAIT_PIPE.
REQ-022 WAIT_PIPE: on the first cycle the pipeline is free, the block issues the same switch action as REQ-020.
REQ-023 Switch action, not last MB: load_start pulses in the same cycle as mb_switch, load coordinates advance, and the next state is WAIT_LOAD.
REQ-024 Switch action, last MB (load x = x_total and y = y_total): no load_start is issued and the next state is DRAIN.
REQ-025 Coordinate advance: x increments; at x_total, x wraps to 0 and y increments; arithmetic is unsigned MB_W-bit.
REQ-026 DRAIN: on pipe_done, frame_done pulses in the next cycle, busy falls in that same cycle, and the next state is IDLE.
REQ-027 Ignored inputs: sys_start outside IDLE; load_done outside WAIT_LOAD; pipe_done while pipe_busy=0.
REQ-028 Simultaneous pipe_done and mb_switch: pipe_busy remains 1, because the set has priority.
REQ-029 Ordering: at most one macroblock is loaded ahead of the pipeline; mb_switch is never issued while the loader buffer is unfilled.

Reset
REQ-030 Values while rst_n=0: state IDLE; every output 0; pipe_busy 0; totals and coordinates 0.
REQ-031 Reset asserted mid-frame: the frame is abandoned immediately, with no frame_done pulse.
REQ-032 After reset is released: the block waits in IDLE for a new sys_start.

Verification
REQ-033 1x1 frame (totals 0,0): sys_start@t0 -> load_start@t1. Then load_done@t5 -> mb_switch@t6 with no load_start. Then pipe_done@t9 -> frame_done@t10 and busy=0@t10.
REQ-034 2x2 frame with pipe_done arriving promptly -> mb_switch sequence cur=(0,0),(1,0),(0,1),(1,1); 4 load_start pulses; exactly one frame_done.
REQ-035 Pipeline slower than loader: load_done arrives while pipe_busy=1 -> state WAIT_PIPE. Then pipe_done@tN -> mb_switch and load_start both @tN+1.
REQ-036 pipe_done and load_done in the same cycle in WAIT_LOAD -> mb_switch in the next cycle, and pipe_busy remains 1.
REQ-037 sys_start and a spurious load_done injected mid-frame -> no change to state or coordinates, and no extra pulses.
REQ-038 rst_n pulled low during WAIT_PIPE of a 3x2 frame -> all outputs 0 immediately. A new sys_start with totals (0,0) then completes normally.
